stack_port_ctrl: RTL
====================

// Module: stack_port_ctrl
// PURPOSE
//  Initiator side of the Stack push/pop interface. Accepts PUSH/POP/PEEK/CLEAR
//  requests from the CPU controller over a valid/ready handshake. Drives clean,
//  isolated push/pop pulses to the edge-triggered Stack, one operation at a time.
//  Keeps a shadow depth count, rejects overflow/underflow, and returns popped or
//  peeked data on a one-cycle response strobe.
// PARAMETERS
//  DW         8   data width; must match the Stack word width
//  MAX_DEPTH  31  usable Stack entries (Stack slot 0 is never written)
//  GAP_CYCLES 1   idle-low cycles after each pulse, >=1, before the next pulse or the response
//  (derived) CW = $clog2(MAX_DEPTH+1) = 5 bits; this is the depth counter width
// PORTS
//  clk        in   1   system clock; all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  req_valid  in   1   request present
//  req_ready  out  1   high only in IDLE; the request is accepted on the edge where valid&&ready
//  req_op     in   2   00 PUSH, 01 POP, 10 PEEK, 11 CLEAR
//  req_data   in   DW  PUSH operand
//  rsp_valid  out  1   one-cycle response strobe
//  rsp_data   out  DW  POP/PEEK result; 0 for PUSH, CLEAR and errors
//  rsp_err    out  1   qualifies rsp_valid: 1 = overflow/underflow, op not performed
//  depth      out  CW  shadow entry count, 0..MAX_DEPTH
//  full       out  1   depth==MAX_DEPTH
//  empty      out  1   depth==0
//  stk_push   out  1   to Stack push (registered pulse)
//  stk_pop    out  1   to Stack pop (registered pulse)
//  stk_d_in   out  DW  to Stack d_in; held stable from the accept edge through the pulse
//  stk_d_out  in   DW  from Stack d_out (current top)
// BEHAVIOUR
//  - Reset: every output register cleared; state=IDLE; depth=0; stk_push=stk_pop=0.
//    full=0, empty=1, req_ready=1 (drain feature off).
//    Reset mid-operation aborts the op on the next edge; no response is issued.
//  - FSM: IDLE -> PULSE (1 cyc) -> GAP (GAP_CYCLES cyc) -> RESP (1 cyc) -> IDLE.
//  - PUSH at accept edge T:
//    stk_d_in<=req_data; stk_push=1 in T+1; low in T+2;
//    depth+1 at the T+2 edge; rsp_valid in cycle T+2+GAP_CYCLES.
//  - POP: rsp_data<=stk_d_out captured at edge T, before the pop;
//    stk_pop pulse in T+1; depth-1; response timing same as PUSH.
//  - PEEK: rsp_data<=stk_d_out at T; no pulse; rsp_valid in T+1.
//  - CLEAR: loops PULSE(pop)/GAP while depth>0; then RESP with err=0.
//    CLEAR at depth 0 -> rsp in T+1.
//  - Errors: PUSH when full, or POP/PEEK when empty -> no pulse, depth unchanged.
//    rsp_valid=1, rsp_err=1, rsp_data=0 in T+1.
//  - stk_push and stk_pop are never high together.
//    Every pulse is exactly one cycle, followed by >=GAP_CYCLES low cycles.
//  - A request held while not ready is ignored; the requester must keep it stable.
//  - depth never wraps: saturation is prevented by the error path.
// CONFIGURATION
//  STK_CTRL_RESET_DRAIN_EN defined: the Stack pointer itself has no reset.
//   After rst deasserts, state DRAIN issues MAX_DEPTH pop pulses, each followed by
//   GAP_CYCLES low cycles. req_ready=0 throughout, then IDLE.
//   Drain time = MAX_DEPTH*(1+GAP_CYCLES) cycles.
//  Not defined: no DRAIN state; IDLE directly after reset. The integrator guarantees
//   the Stack pointer is 0 at reset.
// TESTING
//  1 PUSH 8'hA5 -> stk_push high exactly 1 cycle, stk_d_in=A5, depth=1,
//    rsp_valid at T+3, err=0.
//  2 PUSH 11,22; POP; POP -> rsp_data 22 then 11, err=0, depth 0, empty=1.
//  3 POP at depth 0 -> no stk_pop, rsp_err=1 at T+1; PEEK at depth 0 -> same.
//  4 31 PUSHes then PUSH 8'h7E -> full=1, rsp_err=1, no stk_push, depth stays 31.
//  5 PUSH x5, CLEAR -> exactly 5 stk_pop pulses, each separated by a gap;
//    rsp err=0, depth 0.
//  6 rst mid-POP (in the PULSE cycle) -> stk_pop=0 next cycle, no rsp_valid, depth=0;
//    with drain on: 31 pops, then ready.

Source files
------------

// File: rtl/stack_port_if.sv
// Request/response bundle between the CPU controller (master) and the
// stack port controller (slave).
interface stack_port_if #(
  parameter int DW = 8
) ();
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  modport master (
    output req_valid, req_op, req_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/stack_port_ctrl.sv
// Sequences PUSH/POP/PEEK/CLEAR into isolated one-cycle stk_push/stk_pop pulses
// and tracks a shadow depth. Optional post-reset drain: STK_CTRL_RESET_DRAIN_EN.
module stack_port_ctrl #(
  parameter int DW         = 8,
  parameter int MAX_DEPTH  = 31,
  parameter int GAP_CYCLES = 1,
  localparam int CW        = $clog2(MAX_DEPTH + 1),
  localparam int GW        = $clog2(GAP_CYCLES + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  stack_port_if.slave   req_if,
  output logic [CW-1:0] depth_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          stk_push_o,
  output logic          stk_pop_o,
  output logic [DW-1:0] stk_d_in_o,
  input  logic [DW-1:0] stk_d_out_i
);

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

`ifdef STK_CTRL_RESET_DRAIN_EN
  typedef enum logic [2:0] {S_IDLE, S_PULSE, S_GAP, S_RESP, S_DRAIN} state_e;
  logic [CW-1:0] drain_q;
`else
  typedef enum logic [2:0] {S_IDLE, S_PULSE, S_GAP, S_RESP} state_e;
`endif

  state_e        state_q;
  logic [1:0]    op_q;
  logic [CW-1:0] depth_q;
  logic [CW-1:0] depth_d;
  logic          full_q;
  logic          empty_q;
  logic          push_q;
  logic          pop_q;
  logic [DW-1:0] d_in_q;
  logic [GW-1:0] gap_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [DW-1:0] rsp_data_q;

  // Depth after the operation in flight completes (only PUSH grows the stack).
  always_comb begin
    depth_d = depth_q;
    if (op_q == OP_PUSH) begin
      depth_d = depth_q + CW'(1);
    end else begin
      depth_d = depth_q - CW'(1);
    end
  end

  // Operation sequencer: IDLE -> PULSE -> GAP -> RESP, with CLEAR looping PULSE/GAP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
`ifdef STK_CTRL_RESET_DRAIN_EN
      state_q <= S_DRAIN;
      drain_q <= CW'(MAX_DEPTH);
`else
      state_q <= S_IDLE;
`endif
      op_q        <= OP_PUSH;
      depth_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      d_in_q      <= '0;
      gap_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_if.req_valid) begin
            op_q       <= req_if.req_op;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
            case (req_if.req_op)
              OP_PUSH: begin
                if (full_q) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  state_q     <= S_RESP;
                end else begin
                  d_in_q  <= req_if.req_data;
                  push_q  <= 1'b1;
                  state_q <= S_PULSE;
                end
              end
              OP_POP: begin
                // Top of stack is captured before the pop pulse moves the pointer.
                if (empty_q) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  state_q     <= S_RESP;
                end else begin
                  rsp_data_q <= stk_d_out_i;
                  pop_q      <= 1'b1;
                  state_q    <= S_PULSE;
                end
              end
              OP_PEEK: begin
                rsp_valid_q <= 1'b1;
                state_q     <= S_RESP;
                if (empty_q) begin
                  rsp_err_q <= 1'b1;
                end else begin
                  rsp_data_q <= stk_d_out_i;
                end
              end
              default: begin
                if (empty_q) begin
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
                end else begin
                  pop_q   <= 1'b1;
                  state_q <= S_PULSE;
                end
              end
            endcase
          end
        end
        S_PULSE: begin
          gap_q   <= GW'(GAP_CYCLES - 1);
          state_q <= S_GAP;
        end
        S_GAP: begin
          if (gap_q != '0) begin
            gap_q <= gap_q - GW'(1);
          end
`ifdef STK_CTRL_RESET_DRAIN_EN
          else if (drain_q != '0) begin
            drain_q <= drain_q - CW'(1);
            if (drain_q == CW'(1)) begin
              state_q <= S_IDLE;
            end else begin
              pop_q   <= 1'b1;
              state_q <= S_PULSE;
            end
          end
`endif
          else begin
            depth_q <= depth_d;
            full_q  <= (depth_d == CW'(MAX_DEPTH));
            empty_q <= (depth_d == CW'(0));
            if ((op_q == OP_CLEAR) && (depth_d != CW'(0))) begin
              pop_q   <= 1'b1;
              state_q <= S_PULSE;
            end else begin
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
`ifdef STK_CTRL_RESET_DRAIN_EN
        S_DRAIN: begin
          pop_q   <= 1'b1;
          state_q <= S_PULSE;
        end
`endif
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_if.req_ready = (state_q == S_IDLE);
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_err   = rsp_err_q;
  assign req_if.rsp_data  = rsp_data_q;
  assign depth_o          = depth_q;
  assign full_o           = full_q;
  assign empty_o          = empty_q;
  assign stk_push_o       = push_q;
  assign stk_pop_o        = pop_q;
  assign stk_d_in_o       = d_in_q;

endmodule
